// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// Central stall/flush scheduler for the 5-stage KGP-RISC pipeline. Each cycle
// it decides which pipeline registers advance, hold or take a bubble, based on
// load-use hazards, taken branches, multi-cycle EX operations and data-memory
// wait states. It also keeps saturating hazard counters and a sticky
// memory-timeout flag.
module hazard_sequencer #(
    parameter int MUL_LAT     = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_readdmem,
    input  logic             ex_multi,
    input  logic             br_taken,
    input  logic             dmem_busy,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EX_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Remaining EX occupancy after the first multi-cycle cycle.
    localparam logic [7:0]       BUSY_LOAD   = 8'(MUL_LAT - 1);
    localparam logic [7:0]       TIMEOUT_LIM = 8'(MEM_TIMEOUT);
    localparam logic [7:0]       WAIT_MAX    = 8'hFF;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     state_nxt;
    logic [7:0] busy_cnt;
    logic [7:0] busy_cnt_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       run_rules;
    logic       timeout_set;
    logic       load_use;

    // A load in EX whose destination is read by the ID instruction; r0 never
    // carries a real dependency.
    assign load_use = ex_readdmem && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // Next-state and Mealy pipeline controls; RUN rules 2-5 are shared with
    // the MEM_WAIT release cycle through run_rules.
    always_comb begin
        pc_en        = 1'b1;
        pc_redirect  = 1'b0;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        exmem_flush  = 1'b0;
        memwb_en     = 1'b1;
        state_nxt    = state;
        busy_cnt_nxt = busy_cnt;
        wait_cnt_nxt = wait_cnt;
        run_rules    = 1'b0;
        timeout_set  = 1'b0;

        unique case (state)
            RUN: begin
                if (dmem_busy) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_en     = 1'b0;
                    memwb_en     = 1'b0;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            EX_BUSY: begin
                if (busy_cnt > 8'd1) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idex_en      = 1'b0;
                    exmem_flush  = 1'b1;
                    busy_cnt_nxt = busy_cnt - 8'd1;
                end else begin
                    state_nxt    = RUN;
                    busy_cnt_nxt = 8'd0;
                end
            end
            MEM_WAIT: begin
                if (dmem_busy) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    if (wait_cnt != WAIT_MAX) begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end else begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                    run_rules    = 1'b1;
                end
            end
            default: begin
                state_nxt    = RUN;
                busy_cnt_nxt = 8'd0;
                wait_cnt_nxt = 8'd0;
            end
        endcase

        if (run_rules) begin
            if (ex_multi) begin
                pc_en        = 1'b0;
                ifid_en      = 1'b0;
                idex_en      = 1'b0;
                exmem_flush  = 1'b1;
                busy_cnt_nxt = BUSY_LOAD;
                state_nxt    = EX_BUSY;
            end else if (br_taken) begin
                pc_redirect = 1'b1;
                pc_en       = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        timeout_set = (state_nxt == MEM_WAIT) && (wait_cnt_nxt >= TIMEOUT_LIM);

        if (!rst_n) begin
            pc_en       = 1'b0;
            pc_redirect = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            memwb_en    = 1'b0;
        end
    end

    // Sequencer state and its occupancy/wait counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            busy_cnt <= 8'd0;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= busy_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout <= 1'b0;
        end else if (timeout_set) begin
            mem_timeout <= 1'b1;
        end
    end

    // Saturating hazard performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (!pc_en && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
            if (pc_redirect && (redirect_count != CNT_MAX)) begin
                redirect_count <= redirect_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer
// Scoreboard bench: each driven cycle pushes the reference model's expected
// controls/counters; an independent monitor pops and compares every cycle.
module tb_hazard_sequencer;

    localparam int MUL_LAT     = 4;
    localparam int MEM_TIMEOUT = 2;
    localparam int CNT_W       = 4;
    localparam int CNT_SAT     = (1 << CNT_W) - 1;

    // Control vector order:
    // {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en}
    localparam logic [8:0] CTL_RESET  = 9'b000101010;
    localparam logic [8:0] CTL_ADV    = 9'b101010101;
    localparam logic [8:0] CTL_FREEZE = 9'b000000000;
    localparam logic [8:0] CTL_MULTI  = 9'b000000111;
    localparam logic [8:0] CTL_BRANCH = 9'b111111101;
    localparam logic [8:0] CTL_LOADUS = 9'b000011101;

    typedef struct packed {
        logic [8:0] ctl;
        logic       timeout;
        logic [3:0] stall;
        logic [3:0] redir;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_rd;
    logic             ex_readdmem;
    logic             ex_multi;
    logic             br_taken;
    logic             dmem_busy;
    logic             pc_en;
    logic             pc_redirect;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] redirect_count;

    exp_t exp_q[$];
    int   check_count = 0;
    int   error_count = 0;

    // Reference model: remaining multi-cycle EX slots, consecutive busy run,
    // sticky flag and counters.
    int   m_mul_left  = 0;
    int   m_busy_run  = 0;
    int   m_timeout   = 0;
    int   m_stall     = 0;
    int   m_redirect  = 0;

    hazard_sequencer #(
        .MUL_LAT    (MUL_LAT),
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_rd         (ex_rd),
        .ex_readdmem   (ex_readdmem),
        .ex_multi      (ex_multi),
        .br_taken      (br_taken),
        .dmem_busy     (dmem_busy),
        .pc_en         (pc_en),
        .pc_redirect   (pc_redirect),
        .ifid_en       (ifid_en),
        .ifid_flush    (ifid_flush),
        .idex_en       (idex_en),
        .idex_flush    (idex_flush),
        .exmem_en      (exmem_en),
        .exmem_flush   (exmem_flush),
        .memwb_en      (memwb_en),
        .mem_timeout   (mem_timeout),
        .stall_cycles  (stall_cycles),
        .redirect_count(redirect_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle at the falling edge and push the model's prediction.
    task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic uses_rt, input logic [4:0] rd, input logic ld,
                                 input logic multi, input logic br, input logic busy);
        exp_t e;
        logic hazard;
        @(negedge clk);
        rst_n       = rst;
        id_rs       = rs;
        id_rt       = rt;
        id_uses_rt  = uses_rt;
        ex_rd       = rd;
        ex_readdmem = ld;
        ex_multi    = multi;
        br_taken    = br;
        dmem_busy   = busy;
        if (!rst) begin
            m_mul_left = 0;
            m_busy_run = 0;
            m_timeout  = 0;
            m_stall    = 0;
            m_redirect = 0;
            e.ctl      = CTL_RESET;
            e.timeout  = 1'b0;
            e.stall    = 4'd0;
            e.redir    = 4'd0;
        end else begin
            e.timeout = (m_timeout != 0);
            e.stall   = 4'(m_stall);
            e.redir   = 4'(m_redirect);
            hazard = ld && (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
            if (m_mul_left > 1) begin
                e.ctl = CTL_MULTI;
                m_mul_left--;
            end else if (m_mul_left == 1) begin
                e.ctl = CTL_ADV;
                m_mul_left = 0;
            end else if (busy) begin
                e.ctl = CTL_FREEZE;
                if (m_busy_run < 255) m_busy_run++;
                if (m_busy_run >= MEM_TIMEOUT) m_timeout = 1;
            end else begin
                m_busy_run = 0;
                if (multi) begin
                    e.ctl = CTL_MULTI;
                    m_mul_left = MUL_LAT - 1;
                end else if (br) begin
                    e.ctl = CTL_BRANCH;
                end else if (hazard) begin
                    e.ctl = CTL_LOADUS;
                end else begin
                    e.ctl = CTL_ADV;
                end
            end
            if (!e.ctl[8] && m_stall < CNT_SAT) m_stall++;
            if (e.ctl[7] && m_redirect < CNT_SAT) m_redirect++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare DUT outputs against the oldest pending prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("ctl_vector", 32'({pc_en, pc_redirect, ifid_en, ifid_flush, idex_en,
                                               idex_flush, exmem_en, exmem_flush, memwb_en}), 32'(e.ctl));
                checkOutput("mem_timeout", 32'(mem_timeout), 32'(e.timeout));
                checkOutput("stall_cycles", 32'(stall_cycles), 32'(e.stall));
                checkOutput("redirect_count", 32'(redirect_count), 32'(e.redir));
            end
        end
    end

    initial begin
        logic [4:0] r_rs;
        logic [4:0] r_rt;
        logic [4:0] r_rd;
        int         busy_left;
        logic       r_busy;

        rst_n = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_rd = '0;
        ex_readdmem = 1'b0; ex_multi = 1'b0; br_taken = 1'b0; dmem_busy = 1'b0;

        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();

        // Load-use: lw r5 in EX, add r6,r5,r2 in ID
        applyStimulus(1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("lu_pc_en", 32'(pc_en), 32'd0);
        checkOutput("lu_idex_flush", 32'(idex_flush), 32'd1);
        idle();
        #2;
        checkOutput("lu_release_pc_en", 32'(pc_en), 32'd1);
        checkOutput("lu_stall_count", 32'(stall_cycles), 32'd1);
        applyStimulus(1'b1, 5'd0, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("lu_r0_pc_en", 32'(pc_en), 32'd1);

        // Branch alone, then branch with simultaneous load-use hazard
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        checkOutput("br_flags", 32'({pc_redirect, ifid_flush, idex_flush}), 32'd7);
        applyStimulus(1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        checkOutput("br_count", 32'(redirect_count), 32'd1);
        checkOutput("br_hazard_pc_en", 32'(pc_en), 32'd1);
        idle();

        // Multi-cycle op, with br_taken thrown at it while busy
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, (i > 0), 1'b0);
            #2;
            checkOutput("mul_pc_en", 32'(pc_en), 32'(i == 3));
            checkOutput("mul_exmem_flush", 32'(exmem_flush), 32'(i < 3));
            checkOutput("mul_no_redirect", 32'(pc_redirect), 32'd0);
        end
        idle();

        // Memory wait of 3 cycles with MEM_TIMEOUT=2
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            #2;
            checkOutput("mw_enables", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'd0);
            if (i == 0) checkOutput("mw_timeout_clear", 32'(mem_timeout), 32'd0);
        end
        idle();
        #2;
        checkOutput("mw_release_pc_en", 32'(pc_en), 32'd1);
        checkOutput("mw_timeout_set", 32'(mem_timeout), 32'd1);
        idle();
        #2;
        checkOutput("mw_timeout_sticky", 32'(mem_timeout), 32'd1);

        // Reset in the 2nd EX_BUSY cycle
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        checkOutput("rst_pc_en", 32'(pc_en), 32'd0);
        checkOutput("rst_flushes", 32'({ifid_flush, idex_flush, exmem_flush}), 32'd7);
        checkOutput("rst_counters", 32'({mem_timeout, stall_cycles, redirect_count}), 32'd0);
        idle();
        #2;
        checkOutput("rst_release_pc_en", 32'(pc_en), 32'd1);

        // Saturation: 20 load-use stalls on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle();
        #2;
        checkOutput("sat_stall_cycles", 32'(stall_cycles), 32'd15);

        // Randomized traffic
        busy_left = 0;
        for (int i = 0; i < 3000; i++) begin
            r_rs = 5'($urandom_range(0, 3));
            r_rt = 5'($urandom_range(0, 3));
            r_rd = 5'($urandom_range(0, 3));
            if (busy_left > 0) begin
                r_busy = 1'b1;
                busy_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                r_busy = 1'b1;
                busy_left = $urandom_range(0, 4);
            end else begin
                r_busy = 1'b0;
            end
            applyStimulus(($urandom_range(0, 199) != 0), r_rs, r_rt, 1'($urandom_range(0, 1)), r_rd,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0),
                          ($urandom_range(0, 5) == 0), r_busy);
        end

        #3;
        if (exp_q.size() != 0) begin
            check_count++;
            error_count++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
